// File: rtl/ib_mul_acc.sv
// Sums a stream of unsigned multiplier products into a group total and presents it on a valid/ready handshake.
// Build option: define IB_MUL_ACC_SAT_EN to saturate the accumulator on carry-out instead of wrapping.
module ib_mul_acc #(
    parameter int unsigned PROD_W  = 16,
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned N_TERMS = 16,
    parameter int unsigned CNT_W   = $clog2(N_TERMS + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [PROD_W-1:0] i_c,
    input  logic              i_last,
    output logic              o_ready,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [ACC_W-1:0]  o_sum,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_ovf
);

    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic {
        ST_ACC,
        ST_HOLD
    } state_t;

    state_t state, state_nxt;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf;

    logic [SUM_W-1:0] sum_ext;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             carry;
    logic             accept;
    logic             close;

    always_comb begin
        sum_ext   = {1'b0, acc} + SUM_W'(i_c);
        carry     = sum_ext[ACC_W];
`ifdef IB_MUL_ACC_SAT_EN
        // Once saturated, any further non-zero product carries again, so all-ones sticks.
        acc_nxt   = carry ? '1 : sum_ext[ACC_W-1:0];
`else
        acc_nxt   = sum_ext[ACC_W-1:0];
`endif
        count_nxt = count + CNT_W'(1);
        close     = i_last | (count_nxt == CNT_W'(N_TERMS));
        accept    = i_valid & o_ready;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC:  if (accept && close) state_nxt = ST_HOLD;
            ST_HOLD: if (i_ready)         state_nxt = ST_ACC;
            default: state_nxt = ST_ACC;
        endcase
    end

    always_comb begin
        o_ready = (state == ST_ACC);
        o_valid = (state == ST_HOLD);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc     <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            o_sum   <= '0;
            o_count <= '0;
            o_ovf   <= 1'b0;
        end else if (state == ST_ACC) begin
            if (accept) begin
                acc   <= acc_nxt;
                count <= count_nxt;
                ovf   <= ovf | carry;
                if (close) begin
                    o_sum   <= acc_nxt;
                    o_count <= count_nxt;
                    o_ovf   <= ovf | carry;
                end
            end
        end else if (i_ready) begin
            // Result registers keep the finished group; only the working state is cleared.
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end
    end

endmodule
